// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a boot image source and imem_loader.
// The source drives s_data/s_valid; the loader returns a registered s_ready.
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a 16-bit little-endian word count followed by the payload bytes.
// Payload bytes are packed into little-endian 32-bit words and written to
// consecutive instruction memory addresses. The core is held in reset until
// the whole image has been written.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          arst,
    imem_loader_if.slave  stream,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, CKSUM, DONE, ERR} state_t;
    localparam state_t END_STATE = CKSUM;
    localparam logic   END_READY = 1'b1;
`else
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, DONE, ERR} state_t;
    localparam state_t END_STATE = DONE;
    localparam logic   END_READY = 1'b0;
`endif

    state_t      state;
    logic [7:0]  n_lo;
    logic [15:0] word_count;
    logic [1:0]  lane;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic [15:0] hdr_n;
    logic        hdr_too_big;
    logic        hdr_zero;
    logic [15:0] next_count;
    logic        last_word;

    // Handshake decode and header / end-of-image conditions
    always_comb begin
        accept      = stream.s_valid && stream.s_ready;
        hdr_n       = {stream.s_data, n_lo};
        hdr_too_big = {16'd0, hdr_n} > DEPTH_WORDS;
        hdr_zero    = (hdr_n == 16'd0);
        next_count  = 16'(words_loaded) + 16'd1;
        last_word   = (next_count == word_count);
    end

    // Loader FSM; s_ready is registered alongside the next state so it never
    // depends combinationally on s_valid
    always_ff @(posedge clk) begin
        if (arst) begin
            state          <= HDR0;
            stream.s_ready <= 1'b0;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= '0;
            words_loaded   <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            core_rst       <= 1'b1;
            n_lo           <= '0;
            word_count     <= '0;
            lane           <= '0;
            b0             <= '0;
            b1             <= '0;
            b2             <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) begin
                csum <= csum ^ stream.s_data;
            end
`endif
            case (state)
                HDR0: begin
                    stream.s_ready <= 1'b1;
                    if (accept) begin
                        n_lo  <= stream.s_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        word_count <= hdr_n;
                        if (hdr_too_big) begin
                            state          <= ERR;
                            stream.s_ready <= 1'b0;
                            err            <= 1'b1;
                        end else if (hdr_zero) begin
                            state          <= END_STATE;
                            stream.s_ready <= END_READY;
                        end else begin
                            state <= LOAD;
                            lane  <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: b0 <= stream.s_data;
                            2'd1: b1 <= stream.s_data;
                            2'd2: b2 <= stream.s_data;
                            default: begin
                                // Write strobe lands in the cycle after lane 3,
                                // which is the first cycle of the next state on
                                // the final word
                                imem_we      <= 1'b1;
                                imem_addr    <= words_loaded[AW-1:0];
                                imem_wdata   <= {stream.s_data, b2, b1, b0};
                                words_loaded <= words_loaded + (AW+1)'(1);
                                if (last_word) begin
                                    state          <= END_STATE;
                                    stream.s_ready <= END_READY;
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CKSUM: begin
                    if (accept) begin
                        stream.s_ready <= 1'b0;
                        if (stream.s_data == csum) begin
                            state <= DONE;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    stream.s_ready <= 1'b0;
                    done           <= 1'b1;
                    core_rst       <= 1'b0;
                end
                ERR: begin
                    stream.s_ready <= 1'b0;
                    err            <= 1'b1;
                    core_rst       <= 1'b1;
                end
                default: begin
                    state          <= HDR0;
                    stream.s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of payload words plus
// hand-written sequences for header errors, reset mid-load and checksum.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AWB   = 8;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             imem_we;
    logic [AWB-1:0]   imem_addr;
    logic [31:0]      imem_wdata;
    logic             core_rst;
    logic             done;
    logic             err;
    logic [AWB:0]     words_loaded;

    imem_loader_if bus();

    imem_loader #(.DEPTH_WORDS(DEPTH), .AW(AWB)) dut (
        .clk          (clk),
        .arst         (arst),
        .stream       (bus),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } word_vec_t;

    word_vec_t      vecs[6];
    logic [39:0]    sb[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             writes_seen = 0;
    int             ws;
    logic [AWB-1:0] exp_addr = '0;
    logic [7:0]     xacc = '0;
    logic           we_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin : mon
        logic [39:0] e;
        if (imem_we === 1'b1) begin
            n_vec++;
            writes_seen++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== e || we_prev) begin
                    n_err++;
                    $display("FAIL write: got addr %0h data %h (prev we %0b), expected addr %0h data %h single-cycle",
                             imem_addr, imem_wdata, we_prev, e[39:32], e[31:0]);
                end
            end
        end
        we_prev = imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit took = 1'b0;
        if (gap) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
        end
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 20 && !took; i++) begin
            if (bus.s_ready === 1'b1) took = 1'b1;
            @(negedge clk);
        end
        if (took) begin
            xacc ^= b;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL byte_accept: got no acceptance of %h, expected s_ready within 20 cycles", b);
        end
    endtask

    task automatic send_word(input word_vec_t v, input bit gap);
        sb.push_back({exp_addr, v.exp});
        exp_addr++;
        send_byte(v.b0, gap);
        send_byte(v.b1, gap);
        send_byte(v.b2, gap);
        send_byte(v.b3, gap);
    endtask

    task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xacc, 1'b0);
`endif
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit want_err);
        for (int i = 0; i < 10; i++) begin
            if ((want_err ? err : done) === 1'b1) break;
            @(negedge clk);
        end
        chk(name, want_err ? err : done, 1);
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        exp_addr = '0;
        xacc = '0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 500us");
        $fatal(1);
    end

    initial begin
        word_vec_t v;
        vecs[0] = '{8'h13, 8'h05, 8'h00, 8'h00, 32'h00000513};
        vecs[1] = '{8'h93, 8'h05, 8'h10, 8'h00, 32'h00100593};
        vecs[2] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        vecs[3] = '{8'hff, 8'hff, 8'hff, 8'hff, 32'hffffffff};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000};
        vecs[5] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset values while arst is held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        arst = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", bus.s_ready, 1);
        chk("rel_core_rst", core_rst, 1);

        // Two words back to back, exact done timing
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(vecs[0], 1'b0);
        send_word(vecs[1], 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        chk("t2_last_we", imem_we, 1);
        chk("t2_done_early", done, 0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_core_rst", core_rst, 0);
        chk("t2_s_ready", bus.s_ready, 0);
`else
        finish_stream();
        wait_end("t2_done", 1'b0);
        chk("t2_core_rst", core_rst, 0);
`endif
        chk("t2_words", words_loaded, 2);
        // Bytes offered while not ready are ignored
        bus.s_data  = 8'h55;
        bus.s_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
        chk("t2_ignore_words", words_loaded, 2);
        chk("t2_ignore_done", done, 1);
        chk("t2_ignore_err", err, 0);

        // Same stream with s_valid toggling every cycle
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(vecs[0], 1'b1);
        send_word(vecs[1], 1'b1);
        finish_stream();
        wait_end("t3_done", 1'b0);
        chk("t3_words", words_loaded, 2);
        chk("t3_core_rst", core_rst, 0);

        // Oversized header N=513
        do_reset();
        ws = writes_seen;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        bus.s_valid = 1'b0;
        wait_end("t4_err", 1'b1);
        repeat (3) @(negedge clk);
        chk("t4_core_rst", core_rst, 1);
        chk("t4_s_ready", bus.s_ready, 0);
        chk("t4_done", done, 0);
        chk("t4_writes", writes_seen, ws);

        // Boundary N=257 rejected
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        bus.s_valid = 1'b0;
        wait_end("t4b_err", 1'b1);

        // Boundary N=256 fills memory
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 256; i++) begin
            v.b0 = 8'(i);
            v.b1 = 8'(i + 1);
            v.b2 = 8'(i + 2);
            v.b3 = 8'(i * 3);
            v.exp = {v.b3, v.b2, v.b1, v.b0};
            send_word(v, (i % 7) == 0);
        end
        finish_stream();
        wait_end("full_done", 1'b0);
        chk("full_words", words_loaded, 256);
        chk("full_err", err, 0);

        // Empty image
        do_reset();
        ws = writes_seen;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        finish_stream();
        wait_end("t5_done", 1'b0);
        chk("t5_core_rst", core_rst, 0);
        chk("t5_words", words_loaded, 0);
        chk("t5_writes", writes_seen, ws);

        // Reset after 6 of 8 payload bytes
        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(vecs[2], 1'b0);
        send_byte(vecs[3].b0, 1'b0);
        send_byte(vecs[3].b1, 1'b0);
        bus.s_valid = 1'b0;
        arst = 1'b1;
        @(negedge clk);
        chk("t6_core_rst", core_rst, 1);
        chk("t6_words", words_loaded, 0);
        arst = 1'b0;
        exp_addr = '0;
        xacc = '0;
        @(negedge clk);
        chk("t6_hdr0_ready", bus.s_ready, 1);
        chk("t6_done", done, 0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        v = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA};
        send_word(v, 1'b0);
        finish_stream();
        wait_end("t6_reload_done", 1'b0);
        chk("t6_reload_words", words_loaded, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        v = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        send_word(v, 1'b0);
        send_byte(8'h45, 1'b0);
        bus.s_valid = 1'b0;
        wait_end("t7_good_done", 1'b0);
        chk("t7_good_err", err, 0);
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(v, 1'b0);
        send_byte(8'h46, 1'b0);
        bus.s_valid = 1'b0;
        wait_end("t7_bad_err", 1'b1);
        chk("t7_bad_core_rst", core_rst, 1);
        chk("t7_bad_done", done, 0);
`endif

        // Table-driven load of all vectors, alternating gaps
        do_reset();
        send_byte(8'h06, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i], (i % 2) == 1);
        end
        finish_stream();
        wait_end("tbl_done", 1'b0);
        chk("tbl_words", words_loaded, 6);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the instruction memory and the core.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into the instruction memory write port.
- Holds the core in reset (core_rst) until the image is fully loaded; reports done/err.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words
AW, 8, word-address width; must satisfy 2**AW >= DEPTH_WORDS

Ports:
clk  in  1  system clock, rising edge
arst  in  1  reset; synchronous, active-high, sampled on rising clk
s_data  in  8  incoming stream byte
s_valid  in  1  s_data is valid
s_ready  out  1  loader can accept a byte this cycle
imem_we  out  1  one-cycle write strobe to instruction memory
imem_addr  out  AW  word address of the write
imem_wdata  out  32  word to write
core_rst  out  1  held high to keep the core (PC register, regfile) in reset
done  out  1  image loaded successfully; sticky until arst
err  out  1  load failed; sticky until arst
words_loaded  out  AW+1  count of words written so far

Behaviour:
- Byte transfer occurs on a rising clk when s_valid && s_ready. s_ready is a registered state decode, independent of s_valid; no combinational path from s_valid.
- Stream format: HDR byte0 = N[7:0], HDR byte1 = N[15:8] (word count, little-endian), then 4*N payload bytes (byte0 -> wdata[7:0] ... byte3 -> wdata[31:24]), then one checksum byte only if CHECKSUM_EN.
- States: HDR0 -> HDR1 -> LOAD -> (CKSUM) -> DONE; ERR reachable from HDR1/CKSUM.
- HDR0: s_ready=1; the accepted byte is latched as N low -> HDR1.
- HDR1: s_ready=1; the accepted byte completes N.
  - If N > DEPTH_WORDS -> ERR.
  - If N == 0 -> DONE (or CKSUM if enabled).
  - Otherwise -> LOAD.
- LOAD: s_ready=1; a 2-bit byte-lane counter collects bytes.
  - On acceptance of lane 3, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = current word index and imem_wdata = {b3,b2,b1,b0}.
  - words_loaded increments in that same cycle.
  - Word index starts at 0 and increments by 1; it never wraps because N <= DEPTH_WORDS.
  - Acceptance of the next byte in the same cycle as the imem_we pulse is allowed; full throughput is 1 byte/cycle.
  - After the final word is accepted -> DONE (or CKSUM). The final imem_we pulse fires in the first cycle of the new state.
- DONE: s_ready=0, done=1, core_rst=0. done and core_rst change in the same cycle, one cycle after the final imem_we pulse (for N=0, the cycle after HDR1 acceptance). Absorbing until arst.
- ERR: s_ready=0, err=1, core_rst=1. Absorbing until arst.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset values (cycle after arst sampled high): state=HDR0, s_ready=0 while arst is high (1 from the first cycle after release), imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, done=0, err=0, core_rst=1.
- Reset mid-load:
  - Returns to HDR0 and discards any partial word; no imem_we is issued for it.
  - Memory already written is not cleared.
  - core_rst is reasserted immediately on the reset edge.
- s_valid while s_ready=0: ignored; no state change.

Optional Feature:
Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR covers every accepted byte, header included.
  - After the last payload byte the FSM enters CKSUM (s_ready=1) and accepts one byte.
  - Byte equals running XOR -> DONE; otherwise -> ERR.
  - The checksum byte is not written to memory.
- Undefined: no CKSUM state and no XOR register; the transition after the last payload byte (or N==0) goes directly to DONE, and no trailing byte is consumed.

Test Plan:
1. Hold arst 2 cycles, then release -> core_rst=1, done=0, err=0, words_loaded=0, imem_we=0; s_ready=1 from the first cycle after release.
2. Stream 02 00 | 13 05 00 00 | 93 05 10 00, s_valid held high, no checksum -> imem_we pulses twice: addr0=0x00000513, addr1=0x00100593; words_loaded=2. One cycle after the second pulse: done=1, core_rst=0, s_ready=0.
3. Same stream as 2 with s_valid toggling 1/0 every cycle -> identical writes and final state; no duplicate or dropped bytes.
4. Header 01 02 (N=513 > 256) -> err=1, core_rst stays 1, s_ready=0, no imem_we ever asserted.
5. Header 00 00 -> done=1 and core_rst=0 one cycle after the second header byte; no writes. With CHECKSUM_EN, byte 00 is required first.
6. Mid-stream reset: N=2, assert arst after 6 payload bytes -> word0 written, no write for the partial word, words_loaded=0, state HDR0. A fresh 01 00 AA BB CC DD then writes addr0=0xDDCCBBAA, done=1.
7. With IMEM_LOADER_CHECKSUM_EN, stream 01 00 11 22 33 44 -> checksum 0x45 gives done=1; checksum 0x46 gives err=1, core_rst=1.
